// File: rtl/neuron_pkg.sv
// Shared definitions for the layer-1 neuron sequencer: FSM state encoding
// and the width rule for the surrogate level index.
package neuron_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ACCUM = 3'd1,
      ST_FIRE  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_SURR  = 3'd4,
      ST_FLUSH = 3'd5
   } seq_state_e;

   // Level index must hold 0..n, so it needs clog2(n+1) bits.
   function automatic int level_idx_width(input int n_levels);
      return $clog2(n_levels + 1);
   endfunction

endpackage

// File: rtl/neuron_layer1_sequencer_surr_level_gen.sv
// Surrogate level threshold generator: base + k*step computed with four
// guard bits, then clamped to the signed range of the membrane width.
module surr_level_gen #(
   parameter int W     = 17,
   parameter int LVL_W = 3
) (
   input  logic signed [W-1:0] base_i,
   input  logic signed [W-1:0] step_i,
   input  logic [LVL_W-1:0]    level_i,
   output logic signed [W-1:0] threshold_o
);

   localparam int EW = W + 4;
   localparam logic signed [EW-1:0] SAT_MAX = {{5{1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [EW-1:0] SAT_MIN = {{5{1'b1}}, {(W-1){1'b0}}};

   logic signed [EW-1:0] base_ext;
   logic signed [EW-1:0] step_ext;
   logic signed [EW-1:0] lvl_ext;
   logic signed [EW-1:0] sum;

   // Widen, accumulate, then saturate back into the membrane range.
   always_comb begin
      base_ext = EW'(base_i);
      step_ext = EW'(step_i);
      lvl_ext  = EW'(level_i);
      sum      = base_ext + step_ext * lvl_ext;
      if (sum > SAT_MAX) begin
         threshold_o = SAT_MAX[W-1:0];
      end else if (sum < SAT_MIN) begin
         threshold_o = SAT_MIN[W-1:0];
      end else begin
         threshold_o = sum[W-1:0];
      end
   end

endmodule

// File: rtl/neuron_layer1_sequencer.sv
// Layer-1 neuron sequencer: walks each sample through accumulate, fire and
// (in training) surrogate-box shift plus ascending surrogate level sweeps.
module neuron_layer1_sequencer
   import neuron_pkg::*;
#(
   parameter int BIT_WIDTH_MEMBRANE  = 17,
   parameter int BIT_WIDTH_SURROGATE = 3,
   parameter int N_LEVELS            = 4,
   parameter int BIT_WIDTH_TIMESTEP  = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start_i,
   input  logic                                 abort_i,
   input  logic                                 training_i,
   input  logic [BIT_WIDTH_TIMESTEP-1:0]        num_timesteps_i,
   input  logic                                 accum_done_i,
   input  logic signed [BIT_WIDTH_MEMBRANE-1:0] threshold_fire_i,
   input  logic signed [BIT_WIDTH_MEMBRANE-1:0] surr_base_i,
   input  logic signed [BIT_WIDTH_MEMBRANE-1:0] surr_step_i,
   output logic signed [BIT_WIDTH_MEMBRANE-1:0] threshold_o,
   output logic                                 post_spiking_now_o,
   output logic                                 this_sample_done_o,
   output logic                                 training_state_o,
   output logic                                 surrogate_compute_time_o,
   output logic [BIT_WIDTH_SURROGATE-1:0]       surrogate_ref_o,
   output logic                                 surrogate_read_finish_o,
   output logic                                 busy_o,
   output logic [BIT_WIDTH_TIMESTEP-1:0]        timestep_o,
   output logic                                 sample_done_o
);

   localparam int LVL_W = level_idx_width(N_LEVELS);
   localparam int TS_W  = BIT_WIDTH_TIMESTEP;

   seq_state_e        state_q, state_d;
   logic [TS_W-1:0]   timestep_q, timestep_d;
   logic [TS_W-1:0]   count_q, count_d;
   logic              training_q, training_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              abort_q, abort_d;

   logic                                 last_ts;
   logic signed [BIT_WIDTH_MEMBRANE-1:0] level_thr;

   assign last_ts = (timestep_q == (count_q - TS_W'(1)));

   surr_level_gen #(
      .W     (BIT_WIDTH_MEMBRANE),
      .LVL_W (LVL_W)
   ) u_level_gen (
      .base_i      (surr_base_i),
      .step_i      (surr_step_i),
      .level_i     (level_q),
      .threshold_o (level_thr)
   );

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         timestep_q <= '0;
         count_q    <= '0;
         training_q <= 1'b0;
         level_q    <= '0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         timestep_q <= timestep_d;
         count_q    <= count_d;
         training_q <= training_d;
         level_q    <= level_d;
         abort_q    <= abort_d;
      end
   end

   // Next-state logic; abort_q remembers that the pending FIRE ends the sample.
   always_comb begin
      state_d    = state_q;
      timestep_d = timestep_q;
      count_d    = count_q;
      training_d = training_q;
      level_d    = level_q;
      abort_d    = abort_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               training_d = training_i;
               count_d    = (num_timesteps_i == '0) ? TS_W'(1) : num_timesteps_i;
               timestep_d = '0;
               abort_d    = 1'b0;
               state_d    = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (abort_i) begin
               abort_d = 1'b1;
               state_d = ST_FIRE;
            end else if (accum_done_i) begin
               state_d = ST_FIRE;
            end
         end
         ST_FIRE: begin
            if (abort_q) begin
               state_d = ST_FLUSH;
            end else if (training_q) begin
               state_d = ST_SHIFT;
            end else if (last_ts) begin
               state_d = ST_FLUSH;
            end else begin
               timestep_d = timestep_q + TS_W'(1);
               state_d    = ST_ACCUM;
            end
         end
         ST_SHIFT: begin
            if (abort_i) begin
               abort_d = 1'b1;
               state_d = ST_FIRE;
            end else begin
               level_d = '0;
               state_d = ST_SURR;
            end
         end
         ST_SURR: begin
            if (abort_i) begin
               abort_d = 1'b1;
               level_d = '0;
               state_d = ST_FIRE;
            end else if (level_q == LVL_W'(N_LEVELS - 1)) begin
               level_d = '0;
               if (last_ts) begin
                  state_d = ST_FLUSH;
               end else begin
                  timestep_d = timestep_q + TS_W'(1);
                  state_d    = ST_ACCUM;
               end
            end else begin
               level_d = level_q + LVL_W'(1);
            end
         end
         ST_FLUSH: begin
            abort_d = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control outputs decoded from registered state and counters only.
   always_comb begin
      threshold_o              = threshold_fire_i;
      post_spiking_now_o       = 1'b0;
      this_sample_done_o       = 1'b0;
      surrogate_compute_time_o = 1'b0;
      surrogate_ref_o          = '0;
      surrogate_read_finish_o  = 1'b0;
      sample_done_o            = 1'b0;
      busy_o                   = (state_q != ST_IDLE);
      training_state_o         = (state_q != ST_IDLE) && training_q;
      timestep_o               = timestep_q;
      case (state_q)
         ST_FIRE: begin
            post_spiking_now_o = 1'b1;
            this_sample_done_o = abort_q || last_ts;
         end
         ST_SHIFT: surrogate_read_finish_o = 1'b1;
         ST_SURR: begin
            surrogate_compute_time_o = 1'b1;
            threshold_o              = level_thr;
            surrogate_ref_o          = BIT_WIDTH_SURROGATE'(level_q) + BIT_WIDTH_SURROGATE'(1);
         end
         ST_FLUSH: sample_done_o = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_neuron_layer1_sequencer.sv
// Directed bench for the layer-1 neuron sequencer: inference, training with
// surrogate sweeps, saturation, abort, zero timesteps and mid-sample reset.
module tb_neuron_layer1_sequencer;

   logic               clk = 1'b0;
   logic               reset;
   logic               start_i, abort_i, training_i, accum_done_i;
   logic [7:0]         num_timesteps_i;
   logic signed [16:0] threshold_fire_i, surr_base_i, surr_step_i;
   logic signed [16:0] threshold_o;
   logic               post_spiking_now_o, this_sample_done_o, training_state_o;
   logic               surrogate_compute_time_o, surrogate_read_finish_o;
   logic [2:0]         surrogate_ref_o;
   logic               busy_o, sample_done_o;
   logic [7:0]         timestep_o;

   int total = 0;
   int bad   = 0;

   neuron_layer1_sequencer dut (
      .clk                      (clk),
      .reset                    (reset),
      .start_i                  (start_i),
      .abort_i                  (abort_i),
      .training_i               (training_i),
      .num_timesteps_i          (num_timesteps_i),
      .accum_done_i             (accum_done_i),
      .threshold_fire_i         (threshold_fire_i),
      .surr_base_i              (surr_base_i),
      .surr_step_i              (surr_step_i),
      .threshold_o              (threshold_o),
      .post_spiking_now_o       (post_spiking_now_o),
      .this_sample_done_o       (this_sample_done_o),
      .training_state_o         (training_state_o),
      .surrogate_compute_time_o (surrogate_compute_time_o),
      .surrogate_ref_o          (surrogate_ref_o),
      .surrogate_read_finish_o  (surrogate_read_finish_o),
      .busy_o                   (busy_o),
      .timestep_o               (timestep_o),
      .sample_done_o            (sample_done_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      total++;
      assert (obs === exp)
         $display("t=%0t %s observed=%0d expected=%0d ok", $time, tag, obs, exp);
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; start_i = 0; abort_i = 0; training_i = 0; accum_done_i = 0;
      num_timesteps_i = 8'd0;
      threshold_fire_i = 17'sd1000; surr_base_i = 17'sd100; surr_step_i = 17'sd50;
      tick(); tick();

      // Reset state
      chk("rst_busy", busy_o, 0);
      chk("rst_ts", timestep_o, 0);
      chk("rst_ref", surrogate_ref_o, 0);
      chk("rst_thr", threshold_o, 1000);
      chk("rst_fire", post_spiking_now_o, 0);
      chk("rst_sdone", sample_done_o, 0);
      chk("rst_train", training_state_o, 0);
      reset = 1'b0;

      // Stray accum_done/abort in IDLE are ignored
      accum_done_i = 1; abort_i = 1; tick();
      chk("idle_ignore_busy", busy_o, 0);
      accum_done_i = 0; abort_i = 0;

      // Inference, 3 timesteps, accum_done every 5 cycles
      start_i = 1; training_i = 0; num_timesteps_i = 8'd3; tick();
      start_i = 0;
      chk("inf_busy", busy_o, 1);
      chk("inf_train", training_state_o, 0);
      for (int ts = 0; ts < 3; ts++) begin
         repeat (4) tick();
         chk("inf_wait_fire", post_spiking_now_o, 0);
         accum_done_i = 1; tick(); accum_done_i = 0;
         chk("inf_fire", post_spiking_now_o, 1);
         chk("inf_thisdone", this_sample_done_o, (ts == 2) ? 1 : 0);
         chk("inf_fire_thr", threshold_o, 1000);
         tick();
         chk("inf_no_shift", surrogate_read_finish_o, 0);
         chk("inf_no_surr", surrogate_compute_time_o, 0);
         if (ts < 2) chk("inf_ts", timestep_o, ts + 1);
         else        chk("inf_sdone", sample_done_o, 1);
      end
      tick();
      chk("inf_idle", busy_o, 0);
      chk("inf_sdone_clr", sample_done_o, 0);

      // Training, 2 timesteps, base=100 step=50; start while busy is ignored
      start_i = 1; training_i = 1; num_timesteps_i = 8'd2; tick();
      training_i = 0; num_timesteps_i = 8'd5;
      chk("trn_state", training_state_o, 1);
      tick(); start_i = 0;
      chk("trn_ignore_start_ts", timestep_o, 0);
      for (int ts = 0; ts < 2; ts++) begin
         accum_done_i = 1; tick(); accum_done_i = 0;
         chk("trn_fire", post_spiking_now_o, 1);
         chk("trn_thisdone", this_sample_done_o, (ts == 1) ? 1 : 0);
         tick();
         chk("trn_shift", surrogate_read_finish_o, 1);
         chk("trn_shift_ref", surrogate_ref_o, 0);
         chk("trn_shift_thr", threshold_o, 1000);
         for (int k = 0; k < 4; k++) begin
            tick();
            chk("trn_surr", surrogate_compute_time_o, 1);
            chk("trn_surr_thr", threshold_o, 100 + 50 * k);
            chk("trn_surr_ref", surrogate_ref_o, k + 1);
         end
         tick();
         chk("trn_after_surr", surrogate_compute_time_o, 0);
         chk("trn_after_ref", surrogate_ref_o, 0);
         if (ts == 0) chk("trn_ts", timestep_o, 1);
         else         chk("trn_sdone", sample_done_o, 1);
      end
      tick();
      chk("trn_idle", busy_o, 0);
      chk("trn_idle_train", training_state_o, 0);

      // Saturation: base=65500 step=100
      surr_base_i = 17'sd65500; surr_step_i = 17'sd100;
      start_i = 1; training_i = 1; num_timesteps_i = 8'd1; tick(); start_i = 0;
      accum_done_i = 1; tick(); accum_done_i = 0;
      chk("sat_thisdone", this_sample_done_o, 1);
      tick();
      tick();
      chk("sat_k0", threshold_o, 65500);
      for (int k = 1; k < 4; k++) begin
         tick();
         chk("sat_k", threshold_o, 65535);
      end
      tick();
      chk("sat_sdone", sample_done_o, 1);
      tick();
      surr_base_i = 17'sd100; surr_step_i = 17'sd50;

      // Abort during SURR k=2
      start_i = 1; training_i = 1; num_timesteps_i = 8'd3; tick(); start_i = 0;
      accum_done_i = 1; tick(); accum_done_i = 0;
      chk("abt_fire_first", this_sample_done_o, 0);
      tick(); tick(); tick(); tick();
      chk("abt_k2_ref", surrogate_ref_o, 3);
      abort_i = 1; tick(); abort_i = 0;
      chk("abt_fire", post_spiking_now_o, 1);
      chk("abt_thisdone", this_sample_done_o, 1);
      chk("abt_no_surr", surrogate_compute_time_o, 0);
      tick();
      chk("abt_flush", sample_done_o, 1);
      chk("abt_flush_shift", surrogate_read_finish_o, 0);
      tick();
      chk("abt_idle", busy_o, 0);

      // Abort and accum_done together in ACCUM: abort wins
      start_i = 1; training_i = 0; num_timesteps_i = 8'd2; tick(); start_i = 0;
      abort_i = 1; accum_done_i = 1; tick(); abort_i = 0; accum_done_i = 0;
      chk("abt2_thisdone", this_sample_done_o, 1);
      tick();
      chk("abt2_flush", sample_done_o, 1);
      tick();

      // Zero timesteps treated as one
      start_i = 1; training_i = 0; num_timesteps_i = 8'd0; tick(); start_i = 0;
      accum_done_i = 1; tick(); accum_done_i = 0;
      chk("zero_thisdone", this_sample_done_o, 1);
      tick();
      chk("zero_flush", sample_done_o, 1);
      tick();
      chk("zero_idle", busy_o, 0);

      // Reset asserted mid-SURR, then a normal run
      start_i = 1; training_i = 1; num_timesteps_i = 8'd2; tick(); start_i = 0;
      accum_done_i = 1; tick(); accum_done_i = 0;
      tick(); tick(); tick();
      chk("mrst_in_surr", surrogate_compute_time_o, 1);
      reset = 1; tick(); reset = 0;
      chk("mrst_busy", busy_o, 0);
      chk("mrst_ref", surrogate_ref_o, 0);
      chk("mrst_surr", surrogate_compute_time_o, 0);
      chk("mrst_thr", threshold_o, 1000);
      chk("mrst_train", training_state_o, 0);
      chk("mrst_ts", timestep_o, 0);
      start_i = 1; training_i = 0; num_timesteps_i = 8'd1; tick(); start_i = 0;
      chk("mrst_run_train", training_state_o, 0);
      accum_done_i = 1; tick(); accum_done_i = 0;
      chk("mrst_run_fire", this_sample_done_o, 1);
      tick();
      chk("mrst_run_flush", sample_done_o, 1);
      tick();
      chk("mrst_run_idle", busy_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/neuron_layer1_sequencer.md
NEURON_LAYER1_SEQUENCER -- requirements
Module: neuron_layer1_sequencer

Interface
REQ-001 Parameters SHALL be: BIT_WIDTH_MEMBRANE, default 17, membrane/threshold width; BIT_WIDTH_SURROGATE, default 3, surrogate code width; N_LEVELS, default 4, surrogate threshold levels (1..7); BIT_WIDTH_TIMESTEP, default 8, timestep counter width.
REQ-002 Ports SHALL be: clk in 1 clock; reset in 1 synchronous active-high reset.
REQ-003 start_i in 1, begin sample; abort_i in 1, terminate sample; training_i in 1, training mode, sampled at start.
REQ-004 num_timesteps_i in BIT_WIDTH_TIMESTEP, timesteps per sample, sampled at start; accum_done_i in 1, synapse accumulation for current timestep complete.
REQ-005 threshold_fire_i, surr_base_i, surr_step_i in BIT_WIDTH_MEMBRANE signed, fire threshold, first surrogate level, level increment.
REQ-006 threshold_o out BIT_WIDTH_MEMBRANE signed; post_spiking_now_o out 1; this_sample_done_o out 1; training_state_o out 1; surrogate_compute_time_o out 1; surrogate_ref_o out BIT_WIDTH_SURROGATE; surrogate_read_finish_o out 1 (neuron control bus).
REQ-007 busy_o out 1; timestep_o out BIT_WIDTH_TIMESTEP, current timestep index; sample_done_o out 1, one-cycle pulse at sample end.

Function
REQ-008 FSM states SHALL be IDLE, ACCUM, FIRE, SHIFT, SURR, FLUSH; all control outputs SHALL be decoded from registered state/counters only (no combinational input-to-output paths).
REQ-009 IDLE: start_i=1 SHALL latch training_i and num_timesteps_i (0 treated as 1), clear timestep_o to 0, go to ACCUM next cycle; start_i while not IDLE SHALL be ignored.
REQ-010 ACCUM: on accum_done_i=1 go to FIRE next cycle; otherwise hold indefinitely.
REQ-011 FIRE: exactly one cycle, post_spiking_now_o=1, threshold_o=threshold_fire_i; this_sample_done_o=1 iff timestep_o==latched count-1.
REQ-012 From FIRE: training latched -> SHIFT; else last timestep -> FLUSH; else timestep_o+1, -> ACCUM.
REQ-013 SHIFT: one cycle, surrogate_read_finish_o=1 (clears surrogate box entry 0, advances box), then SURR with level k=0.
REQ-014 SURR: N_LEVELS cycles, k=0..N_LEVELS-1; surrogate_compute_time_o=1, threshold_o=surr_base_i+k*surr_step_i, surrogate_ref_o=k+1; ascending levels so highest exceeded level persists.
REQ-015 Level threshold arithmetic SHALL use BIT_WIDTH_MEMBRANE+4 bits and saturate to signed max/min of BIT_WIDTH_MEMBRANE.
REQ-016 After last SURR level: last timestep -> FLUSH; else timestep_o+1, -> ACCUM.
REQ-017 FLUSH: one cycle, sample_done_o=1, then IDLE; busy_o=1 in every state except IDLE.
REQ-018 Outside FIRE/SURR, threshold_o SHALL equal threshold_fire_i; surrogate_ref_o SHALL be 0 outside SURR.
REQ-019 training_state_o SHALL equal latched training flag while busy, 0 in IDLE.
REQ-020 abort_i=1 in ACCUM, SHIFT or SURR SHALL force FIRE next cycle with this_sample_done_o=1, then FLUSH (no SHIFT/SURR); abort_i in FIRE, FLUSH or IDLE SHALL be ignored.
REQ-021 accum_done_i outside ACCUM SHALL be ignored; abort_i and accum_done_i together in ACCUM: abort wins.

Reset
REQ-022 reset=1 at a clock edge SHALL force IDLE, timestep_o=0, latched flags/count=0, all pulse outputs 0, surrogate_ref_o=0, threshold_o=threshold_fire_i, from any state, including mid-sample.

Structure
REQ-023 State encoding and level-index width (clog2(N_LEVELS+1)) SHALL reside in shared package neuron_pkg.
REQ-024 One sub-module SHALL be natural: surr_level_gen (saturating base+k*step threshold generator); rest flat.

Verification
REQ-025 Inference, num_timesteps=3, accum_done each 5 cycles -> three FIRE pulses, this_sample_done only on third, no SHIFT/SURR, sample_done one cycle after third FIRE.
REQ-026 Training, num_timesteps=2, base=100, step=50, N_LEVELS=4 -> per timestep FIRE, SHIFT, 4 SURR cycles with thresholds 100/150/200/250 and refs 1/2/3/4.
REQ-027 base=65500, step=100 (17 bits) -> threshold_o saturates at 65535 from k=1.
REQ-028 Abort during SURR k=2 -> next cycle FIRE with this_sample_done=1, then FLUSH, then IDLE.
REQ-029 num_timesteps=0 -> exactly one timestep executed; start_i while busy -> ignored.
REQ-030 reset asserted in SURR -> next cycle IDLE, all outputs at reset values; subsequent start runs normally.
